// File: rtl/dmem_port_arbiter_pkg.sv
// Purpose : shared definitions for the data-memory port arbiter.
//   - arb_state_t   : arbiter FSM state (CPU-owned / loader burst locked)
//   - DEF_*         : default DEPTH / STARVE_LIMIT / MAX_BURST
//   - addr_in_range : word-index bounds check against the RAM depth
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_LD  = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_DEPTH        = 101;
  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned DEF_MAX_BURST    = 16;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Purpose : saturating up-counter with synchronous clear.
// Ports   :
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   i_clr      : clear to 0 (wins over i_inc)
//   i_inc      : increment by one, holding at MAX
//   o_count    : current count
module arb_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != WIDTH'(MAX))) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Purpose : shares the single-port data RAM between the CPU MEM stage and an
//           external loader/debug port. CPU has priority; the loader takes idle
//           cycles, is force-granted after STARVE_LIMIT waiting cycles, and may
//           lock the port for a burst of up to MAX_BURST beats.
// Ports   :
//   clk, rst_n                         : clock, synchronous active-low reset
//   MemReadM/MemWriteM/ALUOutM/
//   WriteDataM                         : CPU MEM-stage access (word index)
//   ReadDataM                          : CPU load data (straight from ram_rd)
//   StallM                             : freeze IF..MEM this cycle
//   ld_req/ld_we/ld_last/ld_addr/
//   ld_wdata                           : loader beat request
//   ld_gnt                             : loader beat accepted this cycle
//   ld_rdata/ld_rvalid                 : registered loader read data, 1-cycle valid
//   ram_we/ram_addr/ram_wd/ram_rd      : RAM pins (async read)
//   addr_err                           : owner's access out of range this cycle
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic        ld_last,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  output logic        addr_err
);

  localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  arb_state_t      r_state;
  arb_state_t      w_next_state;
  logic            r_post_burst;
  logic            r_ld_rvalid;
  logic [31:0]     r_ld_rdata;

  logic [WCW-1:0]  w_wait_cnt;
  logic [BCW-1:0]  w_beat_cnt;
  logic            w_cpu_acc;
  logic            w_starve;
  logic            w_gnt;
  logic            w_stall;
  logic            w_beat_clr;
  logic            w_beat_inc;
  logic            w_wait_clr;
  logic            w_wait_inc;
  logic [31:0]     w_addr;
  logic [31:0]     w_wd;
  logic            w_own_wr;
  logic            w_own_acc;
  logic            w_in_range;

  assign w_cpu_acc = MemReadM | MemWriteM;
  assign w_starve  = (w_wait_cnt == WCW'(STARVE_LIMIT));

  // Grant / stall decision and next state. Everything is forced inactive while
  // rst_n is low so a burst cut by reset cannot issue a partial write.
  always_comb begin
    w_gnt        = 1'b0;
    w_stall      = 1'b0;
    w_next_state = r_state;
    w_beat_clr   = 1'b0;
    w_beat_inc   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_CPU: begin
          // Right after a burst the CPU always gets the port if it wants it.
          w_gnt   = ld_req & (~w_cpu_acc | (w_starve & ~r_post_burst));
          w_stall = w_gnt & w_cpu_acc;
          if (w_gnt && !ld_last) begin
            w_next_state = S_LD;
            w_beat_inc   = 1'b1;   // beat_cnt is 0 in S_CPU, so this loads 1
          end else begin
            w_beat_clr   = 1'b1;
          end
        end
        S_LD: begin
          w_gnt   = ld_req;
          w_stall = w_cpu_acc;
          // With w_gnt == ld_req the exit terms collapse to this form.
          if (!ld_req || ld_last || (w_beat_cnt == BCW'(MAX_BURST - 1))) begin
            w_next_state = S_CPU;
            w_beat_clr   = 1'b1;
          end else begin
            w_beat_inc   = 1'b1;
          end
        end
        default: w_next_state = S_CPU;
      endcase
    end
  end

  assign w_wait_clr = w_gnt | ~ld_req;
  assign w_wait_inc = (r_state == S_CPU) & ld_req & ~w_gnt;

  arb_sat_counter #(
    .WIDTH (WCW),
    .MAX   (STARVE_LIMIT)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_wait_clr),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_cnt)
  );

  arb_sat_counter #(
    .WIDTH (BCW),
    .MAX   (MAX_BURST - 1)
  ) u_beat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_beat_clr),
    .i_inc   (w_beat_inc),
    .o_count (w_beat_cnt)
  );

  // RAM-side mux: the loader owns the port exactly when it is granted.
  assign w_addr     = w_gnt ? ld_addr  : ALUOutM;
  assign w_wd       = w_gnt ? ld_wdata : WriteDataM;
  assign w_own_wr   = w_gnt ? ld_we    : MemWriteM;
  assign w_own_acc  = w_gnt | w_cpu_acc;
  assign w_in_range = addr_in_range(w_addr, DEPTH);

  assign ram_addr  = w_addr;
  assign ram_wd    = w_wd;
  assign ram_we    = rst_n & w_own_wr & w_in_range;
  assign addr_err  = rst_n & w_own_acc & ~w_in_range;
  assign ReadDataM = ram_rd;
  assign StallM    = w_stall;
  assign ld_gnt    = w_gnt;
  assign ld_rdata  = r_ld_rdata;
  assign ld_rvalid = r_ld_rvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_CPU;
      r_post_burst <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_ld_rdata   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_post_burst <= (r_state == S_LD) && (w_next_state == S_CPU);
      r_ld_rvalid  <= w_gnt & ~ld_we;
      if (w_gnt && !ld_we) begin
        r_ld_rdata <= w_in_range ? ram_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : directed + randomized bench for dmem_port_arbiter with a
//           transaction-level reference model (owner, wait and burst counts).
module tb_dmem_port_arbiter;

  localparam int unsigned DEPTH        = 101;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned MAX_BURST    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallM;
  logic        ld_req, ld_we, ld_last;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_gnt, ld_rvalid;
  logic        ram_we, addr_err;
  logic [31:0] ram_addr, ram_wd, ram_rd;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .MAX_BURST    (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_last    (ld_last),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rdata   (ld_rdata),
    .ld_rvalid  (ld_rvalid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wd     (ram_wd),
    .ram_rd     (ram_rd),
    .addr_err   (addr_err)
  );

  // RAM contents as a fixed address-derived pattern; word 7 holds 0x1234.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd7) return 32'h0000_1234;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign ram_rd = rom(ram_addr);

  int checks   = 0;
  int failures = 0;

  // Reference model: burst ownership, beats taken, cycles waited.
  bit          m_locked  = 1'b0;
  bit          m_release = 1'b0;
  bit          m_rvalid  = 1'b0;
  int unsigned m_wait    = 0;
  int unsigned m_beats   = 0;
  logic [31:0] m_rdata   = '0;
  bit          e_gnt, e_stall, e_we, e_err;
  logic [31:0] e_addr, e_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MemReadM = 0; MemWriteM = 0; ALUOutM = '0; WriteDataM = '0;
    ld_req = 0; ld_we = 0; ld_last = 0; ld_addr = '0; ld_wdata = '0;
  endtask

  // Compute this cycle's expectations and compare at the falling edge.
  task automatic sample();
    bit cpu, wr, inr;
    @(negedge clk);
    cpu = MemReadM || MemWriteM;
    if (rst_n !== 1'b1) begin
      e_gnt = 0; e_stall = 0;
    end else if (m_locked) begin
      e_gnt = ld_req; e_stall = cpu;
    end else begin
      e_gnt   = ld_req && (!cpu || (m_wait >= STARVE_LIMIT && !m_release));
      e_stall = e_gnt && cpu;
    end
    e_addr = e_gnt ? ld_addr : ALUOutM;
    e_wd   = e_gnt ? ld_wdata : WriteDataM;
    wr     = e_gnt ? ld_we : MemWriteM;
    inr    = e_addr < DEPTH;
    e_we   = (rst_n === 1'b1) && wr && inr;
    e_err  = (rst_n === 1'b1) && (e_gnt || cpu) && !inr;
    chk("ld_gnt",    32'(ld_gnt),    32'(e_gnt));
    chk("StallM",    32'(StallM),    32'(e_stall));
    chk("ram_we",    32'(ram_we),    32'(e_we));
    chk("addr_err",  32'(addr_err),  32'(e_err));
    chk("ram_addr",  ram_addr,       e_addr);
    chk("ram_wd",    ram_wd,         e_wd);
    chk("ReadDataM", ReadDataM,      rom(e_addr));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(m_rvalid));
    chk("ld_rdata",  ld_rdata,       m_rdata);
  endtask

  // Advance the model across the rising edge, then release inputs for change.
  task automatic advance();
    bit was_locked;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_locked = 0; m_release = 0; m_wait = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      was_locked = m_locked;
      m_rvalid = e_gnt && !ld_we;
      if (m_rvalid) m_rdata = (e_addr < DEPTH) ? rom(e_addr) : 32'h0;
      if (e_gnt || !ld_req) m_wait = 0;
      else if (!m_locked && m_wait < STARVE_LIMIT) m_wait++;
      if (m_locked) begin
        if (!ld_req || ld_last || (m_beats + 1 == MAX_BURST)) m_locked = 0;
        else m_beats++;
      end else if (e_gnt && !ld_last) begin
        m_locked = 1; m_beats = 1;
      end
      m_release = was_locked && !m_locked;
    end
    #1;
  endtask

  int  gnt_at, stall_cnt, beats, r;
  bit  done, last_gnt;

  initial begin
    rst_n = 0; idle();
    sample();
    chk("rst_gnt", 32'(ld_gnt), 32'd0);
    chk("rst_rvalid", 32'(ld_rvalid), 32'd0);
    advance();
    sample(); advance();
    rst_n = 1;

    // CPU store with loader idle
    MemWriteM = 1; ALUOutM = 5; WriteDataM = 32'hDEAD;
    sample();
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", ram_addr, 32'd5);
    chk("t1_stall", 32'(StallM), 32'd0);
    chk("t1_gnt", 32'(ld_gnt), 32'd0);
    advance();

    // Loader read on an idle CPU cycle
    idle(); ld_req = 1; ld_addr = 7; ld_last = 1;
    sample(); chk("t2_gnt", 32'(ld_gnt), 32'd1); advance();
    idle();
    sample();
    chk("t2_rvalid", 32'(ld_rvalid), 32'd1);
    chk("t2_rdata", ld_rdata, 32'h1234);
    advance();

    // Starvation: CPU busy every cycle
    idle(); MemReadM = 1; ALUOutM = 3;
    ld_req = 1; ld_we = 1; ld_last = 1; ld_addr = 10; ld_wdata = 32'hCAFE;
    gnt_at = 0; stall_cnt = 0;
    for (int n = 1; n <= 20 && gnt_at == 0; n++) begin
      sample();
      if (StallM) stall_cnt++;
      if (ld_gnt) gnt_at = n;
      advance();
    end
    chk("t3_gnt_cycle", 32'(gnt_at), 32'd9);
    chk("t3_stall_cycles", 32'(stall_cnt), 32'd1);
    ld_req = 0;
    sample(); chk("t3_after_stall", 32'(StallM), 32'd0); advance();

    // 4-beat locked write burst against continuous CPU loads
    idle(); MemReadM = 1; ALUOutM = 4; ld_req = 1; ld_we = 1;
    beats = 0; stall_cnt = 0;
    for (int n = 0; n < 40 && beats < 4; n++) begin
      ld_last = (beats == 3); ld_addr = 32'(20 + beats); ld_wdata = 32'(beats) ^ 32'hA5A5;
      sample();
      if (StallM) stall_cnt++;
      if (ld_gnt) beats++;
      advance();
    end
    chk("t4_beats", 32'(beats), 32'd4);
    chk("t4_stall_cycles", 32'(stall_cnt), 32'd4);
    ld_last = 0; ld_addr = 30;
    sample();
    chk("t4_c5_gnt", 32'(ld_gnt), 32'd0);
    chk("t4_c5_stall", 32'(StallM), 32'd0);
    advance();
    idle(); sample(); advance();

    // Burst without ld_last is cut at MAX_BURST beats
    idle(); ld_req = 1; ld_we = 1;
    beats = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      ld_addr = 32'(40 + n); ld_wdata = 32'(n);
      sample();
      if (ld_gnt) beats++;
      else begin
        done = 1;
        chk("t5_cpu_served", 32'(StallM), 32'd0);
      end
      advance();
      MemReadM = 1; ALUOutM = 6;
    end
    chk("t5_beats", 32'(beats), 32'd16);
    chk("t5_released", 32'(done), 32'd1);
    idle(); sample(); advance();

    // Reset in the middle of a burst
    idle(); ld_req = 1; ld_we = 1; ld_addr = 50;
    repeat (3) begin sample(); advance(); end
    rst_n = 0;
    sample();
    chk("t6_rst_gnt", 32'(ld_gnt), 32'd0);
    chk("t6_rst_we", 32'(ram_we), 32'd0);
    chk("t6_rst_err", 32'(addr_err), 32'd0);
    advance();
    rst_n = 1; ld_addr = 200; MemReadM = 1;
    sample();
    chk("t6_state_cpu", 32'(ld_gnt), 32'd0);
    advance();
    MemReadM = 0;
    sample();
    chk("t6_gnt", 32'(ld_gnt), 32'd1);
    chk("t6_we", 32'(ram_we), 32'd0);
    chk("t6_err", 32'(addr_err), 32'd1);
    advance();
    idle(); sample(); advance();

    // Randomized traffic; loader holds its request until granted
    last_gnt = 0;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      r = $urandom_range(0, 7);
      MemReadM = (r < 4); MemWriteM = (r >= 4 && r < 6);
      ALUOutM = $urandom_range(0, 120); WriteDataM = $urandom;
      if (!ld_req || last_gnt) begin
        ld_req   = ($urandom_range(0, 3) != 0);
        ld_we    = $urandom_range(0, 1) != 0;
        ld_last  = ($urandom_range(0, 3) == 0);
        ld_addr  = $urandom_range(0, 120);
        ld_wdata = $urandom;
      end
      sample();
      last_gnt = ld_gnt;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
